// File: rtl/cpu_trace_emitter.sv
// cpu_trace_emitter
//
// Turns one CPU write-back event into an ASCII trace line and sends it one
// character per clock:
//   register write: ^<time>@<pc>: $<grf> <= <data>#
//   memory write:   ^<time>@<pc>: *<addr> <= <data>#
// Hex fields are always 8 lowercase digits. Decimal fields use the minimal
// number of digits, and time saturates at 9999.
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous active-low reset
//   in_valid    event fields valid
//   in_ready    block is idle and can accept an event (registered)
//   kind        0 = register write, 1 = memory write
//   time_in     14-bit timestamp, printed in decimal
//   pc          instruction address
//   grf         register number (kind = 0)
//   addr        memory address (kind = 1)
//   data        written value
//   char_valid  char holds a valid character (registered)
//   char        ASCII character, 8'h00 when idle (registered)
//   char_ready  consumer takes char this cycle
//   last        high together with the closing '#' (registered)

module cpu_trace_emitter (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        kind,
  input  logic [13:0] time_in,
  input  logic [31:0] pc,
  input  logic [4:0]  grf,
  input  logic [31:0] addr,
  input  logic [31:0] data,
  output logic        char_valid,
  output logic [7:0]  char,
  input  logic        char_ready,
  output logic        last
);

  typedef enum logic [3:0] {
    StIdle, StCaret, StTime, StAt, StPc, StColon, StSp1, StSigil,
    StGrf, StAddr, StSp2, StLt, StEq, StSp3, StData, StHash
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  idx_q, idx_d;      // digit index within a multi-digit field
  logic        kind_q, kind_d;
  logic [15:0] tbcd_q, tbcd_d;    // saturated time as 4 BCD digits
  logic [31:0] pc_q, pc_d;
  logic [4:0]  grf_q, grf_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;

  logic        valid_q, valid_d;
  logic [7:0]  char_q, char_d;
  logic        last_q, last_d;
  logic        ready_q, ready_d;

  // Binary to BCD by shift-and-add-3; input is already limited to 9999.
  function automatic logic [15:0] to_bcd(input logic [13:0] bin);
    logic [29:0] sr;
    sr = {16'h0000, bin};
    for (int i = 0; i < 14; i++) begin
      for (int d = 0; d < 4; d++) begin
        if (sr[14+4*d +: 4] >= 4'd5) begin
          sr[14+4*d +: 4] = sr[14+4*d +: 4] + 4'd3;
        end
      end
      sr = sr << 1;
    end
    return sr[29:14];
  endfunction

  // Nibble i of w counted from the most significant end, as lowercase hex.
  function automatic logic [7:0] hex_char(input logic [31:0] w, input logic [2:0] i);
    logic [31:0] s;
    logic [3:0]  n;
    s = w >> {3'd7 - i, 2'b00};
    n = s[3:0];
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
  endfunction

  function automatic logic [7:0] dec_char(input logic [3:0] n);
    return 8'h30 + {4'h0, n};
  endfunction

  // Decimal digit bookkeeping derived from the latched fields.
  logic [13:0] time_sat;
  logic [2:0]  tdig_last;
  logic [2:0]  tpos;
  logic [15:0] tshift;
  logic [1:0]  grf_tens;
  logic [4:0]  grf_ones;
  logic [2:0]  gdig_last;
  logic        advance;

  always_comb begin
    time_sat = (time_in > 14'd9999) ? 14'd9999 : time_in;

    if (tbcd_q[15:12] != 4'h0) begin
      tdig_last = 3'd3;
    end else if (tbcd_q[11:8] != 4'h0) begin
      tdig_last = 3'd2;
    end else if (tbcd_q[7:4] != 4'h0) begin
      tdig_last = 3'd1;
    end else begin
      tdig_last = 3'd0;
    end

    if (grf_q >= 5'd30) begin
      grf_tens = 2'd3;
      grf_ones = grf_q - 5'd30;
    end else if (grf_q >= 5'd20) begin
      grf_tens = 2'd2;
      grf_ones = grf_q - 5'd20;
    end else if (grf_q >= 5'd10) begin
      grf_tens = 2'd1;
      grf_ones = grf_q - 5'd10;
    end else begin
      grf_tens = 2'd0;
      grf_ones = grf_q;
    end
    gdig_last = (grf_tens != 2'd0) ? 3'd1 : 3'd0;
  end

  // Next-state and field latching.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    kind_d  = kind_q;
    tbcd_d  = tbcd_q;
    pc_d    = pc_q;
    grf_d   = grf_q;
    addr_d  = addr_q;
    data_d  = data_q;
    advance = valid_q && char_ready;

    case (state_q)
      StIdle: begin
        if (in_valid && ready_q) begin
          state_d = StCaret;
          idx_d   = 3'd0;
          kind_d  = kind;
          tbcd_d  = to_bcd(time_sat);
          pc_d    = pc;
          grf_d   = grf;
          addr_d  = addr;
          data_d  = data;
        end
      end
      StCaret: if (advance) state_d = StTime;
      StTime: begin
        if (advance) begin
          if (idx_q == tdig_last) begin
            state_d = StAt;
            idx_d   = 3'd0;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      StAt: if (advance) state_d = StPc;
      StPc: begin
        if (advance) begin
          if (idx_q == 3'd7) begin
            state_d = StColon;
            idx_d   = 3'd0;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      StColon: if (advance) state_d = StSp1;
      StSp1:   if (advance) state_d = StSigil;
      StSigil: if (advance) state_d = kind_q ? StAddr : StGrf;
      StGrf: begin
        if (advance) begin
          if (idx_q == gdig_last) begin
            state_d = StSp2;
            idx_d   = 3'd0;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      StAddr: begin
        if (advance) begin
          if (idx_q == 3'd7) begin
            state_d = StSp2;
            idx_d   = 3'd0;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      StSp2: if (advance) state_d = StLt;
      StLt:  if (advance) state_d = StEq;
      StEq:  if (advance) state_d = StSp3;
      StSp3: if (advance) state_d = StData;
      StData: begin
        if (advance) begin
          if (idx_q == 3'd7) begin
            state_d = StHash;
            idx_d   = 3'd0;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      StHash:  if (advance) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs are computed from the next state so that they can be registered
  // without adding a cycle of latency. Fields are always latched by the time
  // a field-dependent state is entered.
  always_comb begin
    valid_d = (state_d != StIdle);
    last_d  = (state_d == StHash);
    ready_d = (state_d == StIdle);
    tpos    = tdig_last - idx_d;
    tshift  = tbcd_q >> {tpos, 2'b00};

    case (state_d)
      StIdle:  char_d = 8'h00;
      StCaret: char_d = "^";
      StTime:  char_d = dec_char(tshift[3:0]);
      StAt:    char_d = "@";
      StPc:    char_d = hex_char(pc_q, idx_d);
      StColon: char_d = ":";
      StSp1:   char_d = " ";
      StSigil: char_d = kind_q ? "*" : "$";
      StGrf: begin
        if (idx_d == 3'd0 && grf_tens != 2'd0) begin
          char_d = dec_char({2'b00, grf_tens});
        end else begin
          char_d = dec_char(grf_ones[3:0]);
        end
      end
      StAddr:  char_d = hex_char(addr_q, idx_d);
      StSp2:   char_d = " ";
      StLt:    char_d = "<";
      StEq:    char_d = "=";
      StSp3:   char_d = " ";
      StData:  char_d = hex_char(data_q, idx_d);
      StHash:  char_d = "#";
      default: char_d = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      idx_q   <= 3'd0;
      kind_q  <= 1'b0;
      tbcd_q  <= 16'h0000;
      pc_q    <= 32'h0;
      grf_q   <= 5'd0;
      addr_q  <= 32'h0;
      data_q  <= 32'h0;
      valid_q <= 1'b0;
      char_q  <= 8'h00;
      last_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      kind_q  <= kind_d;
      tbcd_q  <= tbcd_d;
      pc_q    <= pc_d;
      grf_q   <= grf_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      char_q  <= char_d;
      last_q  <= last_d;
      ready_q <= ready_d;
    end
  end

  assign in_ready   = ready_q;
  assign char_valid = valid_q;
  assign char       = char_q;
  assign last       = last_q;

endmodule
